// File: rtl/prt_slot_scheduler_pkg.sv
// Shared types for the PRT slot scheduler: slot lifecycle states and small helpers.
package prt_slot_scheduler_pkg;

  typedef logic bool_t;
  localparam bool_t TRUE  = 1'b1;
  localparam bool_t FALSE = 1'b0;

  localparam int NUM_SLOTS_DEF = 4;

  typedef enum logic [2:0] {
    SLOT_FREE,
    SLOT_WRITING,
    SLOT_WRITING_PASS,
    SLOT_WRITTEN,
    SLOT_QUEUED,
    SLOT_READING
  } slot_state_e;

  // A slot is "being written" whether or not its pass verdict already arrived.
  function automatic bool_t is_writing(input slot_state_e s);
    return (s == SLOT_WRITING) || (s == SLOT_WRITING_PASS);
  endfunction

endpackage

// File: rtl/prt_slot_scheduler_fifo.sv
// In-order queue of passed slot indices; two push ports so an rx_done completion and a
// verdict completion in the same cycle both enqueue (port a first).
module prt_slot_scheduler_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_a,
  input  logic [W-1:0] din_a,
  input  logic         push_b,
  input  logic [W-1:0] din_b,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (pop) begin
      rd_d  = ptr_inc(rd_q);
      cnt_d = cnt_d - CW'(1);
    end
    if (push_a) begin
      mem_d[wr_d] = din_a;
      wr_d        = ptr_inc(wr_d);
      cnt_d       = cnt_d + CW'(1);
    end
    if (push_b) begin
      mem_d[wr_d] = din_b;
      wr_d        = ptr_inc(wr_d);
      cnt_d       = cnt_d + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/prt_slot_scheduler.sv
// PRT slot lifecycle owner: allocation to RX, firewall verdicts, ordered TX hand-off and freeing.
module prt_slot_scheduler
  import prt_slot_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_alloc_req,
  output logic              rx_alloc_gnt,
  output logic [SLOT_W-1:0] rx_alloc_slot,
  input  logic              rx_done,
  output logic              rx_kill,
  input  logic              fw_verdict_valid,
  input  logic [SLOT_W-1:0] fw_verdict_slot,
  input  logic              fw_verdict_pass,
  output logic              tx_req_valid,
  output logic [SLOT_W-1:0] tx_req_slot,
  input  logic              tx_req_ready,
  input  logic              tx_done,
  output logic              prt_inval_valid,
  output logic [SLOT_W-1:0] prt_inval_slot,
  output logic              slot_free,
  output logic              err_pulse
);
  slot_state_e       st_q [NUM_SLOTS];
  slot_state_e       st_d [NUM_SLOTS];
  bool_t             rx_kill_q, rx_kill_d, inval_valid_q, inval_valid_d, err_q, err_d;
  logic [SLOT_W-1:0] inval_slot_q, inval_slot_d;

  bool_t             any_free, wr_busy, rd_busy;
  logic [SLOT_W-1:0] low_free, wr_slot, rd_slot;
  bool_t             push_a, push_b, pop, fifo_empty, tx_acc;
  logic [SLOT_W-1:0] fifo_head;
  slot_state_e       vst;

  // Descending scan so the lowest-index FREE slot wins.
  always_comb begin
    any_free = FALSE;
    wr_busy  = FALSE;
    rd_busy  = FALSE;
    low_free = '0;
    wr_slot  = '0;
    rd_slot  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (st_q[i] == SLOT_FREE) begin
        any_free = TRUE;
        low_free = SLOT_W'(i);
      end
      if (is_writing(st_q[i])) begin
        wr_busy = TRUE;
        wr_slot = SLOT_W'(i);
      end
      if (st_q[i] == SLOT_READING) begin
        rd_busy = TRUE;
        rd_slot = SLOT_W'(i);
      end
    end
  end

  // TX handshake: tx_req_valid/tx_req_slot are held until tx_req_ready is seen with valid
  // high; the transfer happens on that edge and valid does not depend on ready.
  assign slot_free     = any_free & ~wr_busy & ~rst;
  assign rx_alloc_gnt  = rx_alloc_req & slot_free;
  assign rx_alloc_slot = rx_alloc_gnt ? low_free : '0;
  assign tx_req_valid  = ~fifo_empty & ~rd_busy & ~rst;
  assign tx_req_slot   = tx_req_valid ? fifo_head : '0;
  assign tx_acc        = tx_req_valid & tx_req_ready;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) st_d[i] = st_q[i];
    push_a        = FALSE;
    push_b        = FALSE;
    pop           = FALSE;
    rx_kill_d     = FALSE;
    inval_valid_d = FALSE;
    inval_slot_d  = '0;
    err_d         = FALSE;
    vst           = SLOT_FREE;
    if (rx_done) begin
      if (!wr_busy) begin
        err_d = TRUE;
      end else if (st_q[wr_slot] == SLOT_WRITING_PASS) begin
        st_d[wr_slot] = SLOT_QUEUED;
        push_a        = TRUE;
      end else begin
        st_d[wr_slot] = SLOT_WRITTEN;
      end
    end
    // The verdict sees the slot after a same-cycle rx_done, so a completed frame is never killed.
    if (fw_verdict_valid) begin
      vst = st_d[fw_verdict_slot];
      case (vst)
        SLOT_WRITING, SLOT_WRITING_PASS: begin
          if (!fw_verdict_pass) begin
            st_d[fw_verdict_slot] = SLOT_FREE;
            rx_kill_d             = TRUE;
            inval_valid_d         = TRUE;
            inval_slot_d          = fw_verdict_slot;
          end else if (vst == SLOT_WRITING) begin
            st_d[fw_verdict_slot] = SLOT_WRITING_PASS;
          end else begin
            err_d = TRUE;
          end
        end
        SLOT_WRITTEN: begin
          if (fw_verdict_pass) begin
            st_d[fw_verdict_slot] = SLOT_QUEUED;
            push_b                = TRUE;
          end else begin
            st_d[fw_verdict_slot] = SLOT_FREE;
            inval_valid_d         = TRUE;
            inval_slot_d          = fw_verdict_slot;
          end
        end
        default: err_d = TRUE;
      endcase
    end
    if (tx_done) begin
      if (rd_busy) st_d[rd_slot] = SLOT_FREE;
      else         err_d = TRUE;
    end
    if (tx_acc) begin
      st_d[fifo_head] = SLOT_READING;
      pop             = TRUE;
    end
    if (rx_alloc_gnt) st_d[low_free] = SLOT_WRITING;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) st_q[i] <= SLOT_FREE;
      rx_kill_q     <= FALSE;
      inval_valid_q <= FALSE;
      inval_slot_q  <= '0;
      err_q         <= FALSE;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) st_q[i] <= st_d[i];
      rx_kill_q     <= rx_kill_d;
      inval_valid_q <= inval_valid_d;
      inval_slot_q  <= inval_slot_d;
      err_q         <= err_d;
    end
  end

  assign rx_kill         = rx_kill_q;
  assign prt_inval_valid = inval_valid_q;
  assign prt_inval_slot  = inval_slot_q;
  assign err_pulse       = err_q;

  prt_slot_scheduler_fifo #(
    .DEPTH (NUM_SLOTS),
    .W     (SLOT_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_a (push_a),
    .din_a  (wr_slot),
    .push_b (push_b),
    .din_b  (fw_verdict_slot),
    .pop    (pop),
    .head   (fifo_head),
    .empty  (fifo_empty)
  );

endmodule
